// File: rtl/qwi12_led_pkg.sv
// Shared definitions for the qwi12 LED controller.
// The mode encoding matches the values written by PS software.
package qwi12_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_t;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

endpackage

// File: rtl/qwi12_led_chan.sv
// One LED channel: holds its mode, level and animation state, and
// registers the PWM compare that drives the pin.
module qwi12_led_chan
    import qwi12_led_pkg::*;
#(
    parameter int PWM_W       = 8,
    parameter int BLINK_TICKS = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             wr_en,
    input  logic [1:0]       wr_mode,
    input  logic [PWM_W-1:0] wr_level,
    output logic             led
);

    localparam int BC_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_TICKS - 1);

    led_mode_t        mode;
    logic [PWM_W-1:0] level;
    logic [PWM_W-1:0] ramp;
    logic             ramp_down;
    logic             phase;
    logic [BC_W-1:0]  blink_cnt;
    logic [PWM_W-1:0] duty;
    logic             full_on;

    always_comb begin
        duty = '0;
        case (mode)
            LED_ON:      duty = level;
            LED_BLINK:   duty = phase ? level : '0;
            LED_BREATHE: duty = ramp;
            default:     duty = '0;
        endcase
    end

    // duty > pwm_cnt can never light all 2^PWM_W clocks, so ON at full scale is forced
    assign full_on = (mode == LED_ON) && (&level);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= LED_OFF;
            level     <= '0;
            ramp      <= '0;
            ramp_down <= 1'b0;
            phase     <= 1'b1;
            blink_cnt <= '0;
            led       <= 1'b0;
        end else begin
            led <= full_on || (duty > pwm_cnt);
            // A write restarts the animation and swallows a coincident tick
            if (wr_en) begin
                mode      <= led_mode_t'(wr_mode);
                level     <= wr_level;
                ramp      <= '0;
                ramp_down <= 1'b0;
                phase     <= 1'b1;
                blink_cnt <= '0;
            end else if (tick) begin
                if (blink_cnt == BC_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end

                if (level == '0) begin
                    ramp      <= '0;
                    ramp_down <= 1'b0;
                end else if (!ramp_down) begin
                    ramp <= ramp + 1'b1;
                    if (ramp == level - 1'b1) ramp_down <= 1'b1;
                end else begin
                    ramp <= ramp - 1'b1;
                    if (ramp == PWM_W'(1)) ramp_down <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/qwi12_led_ctrl.sv
// Multi-channel LED controller: shared tick prescaler and PWM counter,
// configuration write decode and acknowledge, one channel per LED.
module qwi12_led_ctrl
    import qwi12_led_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int PWM_W       = 8,
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 250,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [PWM_W-1:0]  cfg_level,
    output logic              cfg_ack,
    output logic [NUM_CH-1:0] led
);

    localparam int PS_W = $clog2(TICK_DIV);

    logic [PS_W-1:0]   presc;
    logic              tick;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              ch_ok;
    logic [NUM_CH-1:0] wr_en;

    assign tick  = (presc == PS_W'(TICK_DIV - 1));
    assign ch_ok = (32'(cfg_ch) < NUM_CH);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
            cfg_ack <= 1'b0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            cfg_ack <= cfg_wr && ch_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_en[i] = cfg_wr && ch_ok && (cfg_ch == CH_W'(i));

        qwi12_led_chan #(
            .PWM_W       (PWM_W),
            .BLINK_TICKS (BLINK_TICKS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .pwm_cnt  (pwm_cnt),
            .wr_en    (wr_en[i]),
            .wr_mode  (cfg_mode),
            .wr_level (cfg_level),
            .led      (led[i])
        );
    end

endmodule

// File: tb/tb_qwi12_led_ctrl.sv
// Directed bench for qwi12_led_ctrl with PWM_W=4, TICK_DIV=4, BLINK_TICKS=2;
// a second instance with NUM_CH=3 covers the out-of-range channel write.
module tb_qwi12_led_ctrl;
    import qwi12_led_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_wr;
    logic       cfg_wr3;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_level;
    logic       cfg_ack;
    logic       cfg_ack3;
    logic [3:0] led;
    logic [2:0] led3;

    int cyc;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Edges since reset release; sampled at negedge it equals the last edge index
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    qwi12_led_ctrl #(
        .NUM_CH(4), .PWM_W(4), .TICK_DIV(4), .BLINK_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_level(cfg_level), .cfg_ack(cfg_ack), .led(led)
    );

    qwi12_led_ctrl #(
        .NUM_CH(3), .PWM_W(4), .TICK_DIV(4), .BLINK_TICKS(2)
    ) dut3 (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_level(cfg_level), .cfg_ack(cfg_ack3), .led(led3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle write and checks the acknowledge on the following cycle
    task automatic write(input bit sel, input logic [1:0] ch, input logic [1:0] mode,
                         input logic [3:0] level, input logic exp_ack, input string tag);
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_level = level;
        if (sel) cfg_wr3 = 1'b1;
        else     cfg_wr  = 1'b1;
        @(negedge clk);
        cfg_wr  = 1'b0;
        cfg_wr3 = 1'b0;
        check(tag, sel ? cfg_ack3 : cfg_ack, exp_ack);
    endtask

    task automatic wait_until(input int c);
        int guard = 0;
        while (cyc != c && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_until", cyc, c);
    endtask

    task automatic count_led(input int n, input logic [3:0] mask, output int lit, output int other);
        lit   = 0;
        other = 0;
        repeat (n) begin
            @(negedge clk);
            if ((led & mask) == mask) lit++;
            if ((led & ~mask) != 4'b0) other++;
        end
    endtask

    initial begin
        int lit, other, cnt;
        int d0, d3, pwm;
        logic [3:0] exp_led;
        int seq0[6] = '{0, 1, 2, 3, 2, 1};
        int seq3[4] = '{0, 1, 2, 1};

        rst = 1'b1; cfg_wr = 1'b0; cfg_wr3 = 1'b0;
        cfg_ch = 2'd0; cfg_mode = 2'd0; cfg_level = 4'd0;

        // Reset held for three edges
        repeat (3) @(negedge clk);
        check("reset_led",  led,      4'b0000);
        check("reset_ack",  cfg_ack,  1'b0);
        check("reset_led3", led3,     3'b000);
        check("reset_ack3", cfg_ack3, 1'b0);
        rst = 1'b0;
        cnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (led != 4'b0 || led3 != 3'b0) cnt++;
        end
        check("reset_dark_64", cnt, 0);

        // NUM_CH=3: ch2 full on, then a write to ch3 is ignored
        write(1'b1, 2'd2, LED_ON, 4'd15, 1'b1, "ack3_ch2");
        write(1'b1, 2'd3, LED_OFF, 4'd0, 1'b0, "ack3_ch3_oor");
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (led3 == 3'b100) cnt++;
            check("ack3_quiet", cfg_ack3, 1'b0);
        end
        check("oor_no_change", cnt, 16);

        // ON level 5 on ch1: 5 lit clocks per 16
        write(1'b0, 2'd1, LED_ON, 4'd5, 1'b1, "ack_on5");
        @(negedge clk);
        check("ack_on5_pulse", cfg_ack, 1'b0);
        count_led(16, 4'b0010, lit, other);
        check("on5_lit", lit, 5);
        check("on5_others_dark", other, 0);

        // ON level 15 is constant full on
        write(1'b0, 2'd1, LED_ON, 4'd15, 1'b1, "ack_on15");
        count_led(16, 4'b0010, lit, other);
        check("on15_lit", lit, 16);
        write(1'b0, 2'd1, LED_OFF, 4'd0, 1'b1, "ack_off1");

        // BLINK level 15 on ch2, write on edge 120 (tick edge, pwm phase 8)
        wait_until(119);
        write(1'b0, 2'd2, LED_BLINK, 4'd15, 1'b1, "ack_blink");
        count_led(8, 4'b0100, lit, other);
        check("blink_half1_lit", lit, 7);
        check("blink_others_dark", other, 0);
        count_led(8, 4'b0100, lit, other);
        check("blink_half2_dark", lit, 0);
        count_led(8, 4'b0100, lit, other);
        check("blink_half3_lit", lit, 7);
        count_led(8, 4'b0100, lit, other);
        check("blink_half4_dark", lit, 0);
        write(1'b0, 2'd2, LED_OFF, 4'd0, 1'b1, "ack_off2");

        // BREATHE level 3 on ch0 written on edge 164; ch3 BREATHE 2 written on tick edge 184
        wait_until(163);
        write(1'b0, 2'd0, LED_BREATHE, 4'd3, 1'b1, "ack_breathe0");
        for (int m = 165; m <= 244; m++) begin
            if (m == 184) begin
                cfg_ch = 2'd3; cfg_mode = LED_BREATHE; cfg_level = 4'd2; cfg_wr = 1'b1;
            end
            @(negedge clk);
            if (m == 184) begin
                cfg_wr = 1'b0;
                check("ack_ch3_tick", cfg_ack, 1'b1);
            end
            pwm = (m - 1) % 16;
            d0  = seq0[((m - 165) / 4) % 6];
            d3  = (m > 184) ? seq3[((m - 185) / 4) % 4] : 0;
            exp_led = {(d3 > pwm), 2'b00, (d0 > pwm)};
            check($sformatf("breathe_m%0d", m), led, exp_led);
        end

        // Back-to-back writes on consecutive cycles
        cfg_ch = 2'd0; cfg_mode = LED_ON; cfg_level = 4'd15; cfg_wr = 1'b1;
        @(negedge clk);
        check("b2b_ack0", cfg_ack, 1'b1);
        cfg_ch = 2'd1;
        @(negedge clk);
        check("b2b_ack1", cfg_ack, 1'b1);
        cfg_wr = 1'b0;
        @(negedge clk);
        check("b2b_ack_end", cfg_ack, 1'b0);
        count_led(16, 4'b0011, lit, other);
        check("b2b_both_on", lit, 16);

        // Reset with a simultaneous write while ch3 is breathing
        rst = 1'b1;
        cfg_ch = 2'd2; cfg_mode = LED_ON; cfg_level = 4'd15; cfg_wr = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cfg_wr = 1'b0;
        check("midrst_ack",  cfg_ack, 1'b0);
        check("midrst_led",  led,     4'b0000);
        check("midrst_led3", led3,    3'b000);
        cnt = 0;
        repeat (32) begin
            @(negedge clk);
            if (led != 4'b0 || led3 != 3'b0 || cfg_ack != 1'b0) cnt++;
        end
        check("midrst_all_off", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/qwi12_led_ctrl.md
# qwi12_led_ctrl

Parametrised multi-channel LED controller for the qwi12 PL fabric, replacing the direct single-bit GPIO-to-LED connection with per-channel PWM brightness, blink and breathe modes. It sits in the top wrapper beside the PS `system` block. PS-side GPIO or register logic drives a simple one-cycle configuration write port, and the block drives `NUM_CH` LED pins from registers.

## Interface

- `NUM_CH`, 4: number of LED channels (1..16).
- `PWM_W`, 8: PWM counter and brightness width. The PWM period is 2^PWM_W clocks.
- `TICK_DIV`, 50000: clocks per animation tick (≥2).
- `BLINK_TICKS`, 250: ticks per blink half-period (≥1).
- `CH_W`, derived `$clog2(NUM_CH)` (min 1): channel index width.

Ports:

- `clk`, in, 1: single clock for all logic.
- `rst`, in, 1: synchronous, active-high reset.
- `cfg_wr`, in, 1: one-cycle configuration write strobe.
- `cfg_ch`, in, CH_W: target channel.
- `cfg_mode`, in, 2: `led_mode_t` value.
- `cfg_level`, in, PWM_W: brightness (ON/BLINK) or peak (BREATHE).
- `cfg_ack`, out, 1: pulses high for one cycle after an accepted write.
- `led`, out, NUM_CH: registered LED drive, 1 = lit.

## Operation

- Reset state: `led`=0, `cfg_ack`=0, all channels OFF with level 0, prescaler 0, PWM counter 0, ramps 0 counting up, blink phase 1, blink counter 0.
- Shared prescaler counts 0..TICK_DIV-1 and asserts `tick` for one clock at wrap.
- Shared `pwm_cnt` (PWM_W bits) increments every clock and wraps naturally.
- Per-channel duty by mode:
  - OFF (0): duty 0.
  - ON (1): duty = level.
  - BLINK (2): duty = phase ? level : 0. The blink counter counts ticks 0..BLINK_TICKS-1, and phase toggles at its wrap.
  - BREATHE (3): duty = ramp. On each tick the ramp steps ±1 as a triangle between 0 and level, reversing to down on reaching level and to up on reaching 0. With level 0 the ramp holds at 0.
- Output compare: lit when duty > pwm_cnt. Exception: the ON mode with level all-ones is forced to a constant 1 (full on).
- Config write:
  - If `cfg_ch` ≥ NUM_CH, the write is ignored and `cfg_ack` stays 0.
  - Otherwise the target channel loads mode and level and restarts its animation: ramp 0 counting up, blink phase 1, blink counter 0.
  - `cfg_ack` pulses once per accepted write. Back-to-back writes on consecutive cycles are all accepted.
- Simultaneous write and tick on the same channel: the write wins and that tick is not applied to the channel. Other channels advance normally.
- Shared counters are never disturbed by writes.
- Reset asserted mid-operation returns everything to the reset state on the next edge, including a write presented in the same cycle (dropped).

## Timing

- `cfg_wr` sampled at edge N: channel state updated at N, `cfg_ack`=1 during cycle N+1, `led` reflects the new config from edge N+1 (one-clock compare register).
- `led` is a pure register output with no combinational path from inputs.
- PWM period is 2^PWM_W clocks. Lit clocks per period equal duty, or 2^PWM_W for forced full on.
- Blink full period is 2·BLINK_TICKS·TICK_DIV clocks.
- Breathe full period is 2·level ticks.
- All counters are unsigned. Ramp never exceeds level and never underflows.

## Structure

- Package `qwi12_led_pkg`: `led_mode_t` enum (2 bits: LED_OFF, LED_ON, LED_BLINK, LED_BREATHE) and the mode encoding constants shared with PS software headers.
- Sub-module `qwi12_led_chan`, one instance per channel via generate. It holds mode, level, ramp, direction, blink counter and phase, and takes `tick`, `pwm_cnt` and a per-channel write enable.
- The top holds the prescaler, the PWM counter, the write decode and `cfg_ack`.

## Test plan

All scenarios use PWM_W=4, TICK_DIV=4, BLINK_TICKS=2, NUM_CH=4.

- Reset: hold `rst` 3 cycles → `led`=4'b0000, `cfg_ack`=0. No LED lit over 64 cycles.
- ON level 5 on ch1: exactly 5 lit clocks per 16-clock window on `led[1]`. `cfg_ack` appears one cycle after `cfg_wr`. ON level 15 gives constant 1.
- BLINK level 15 on ch2: `led[2]` is PWM-lit for 8 clocks (2 ticks × 4), then dark for 8, repeating. The first half after the write is lit.
- BREATHE level 3 on ch0: duty sequence per tick is 0,1,2,3,2,1,0,1…, with lit clocks per PWM window matching the duty.
- Boundaries:
  - A write to ch3 coinciding with a tick restarts ch3 only, with no ramp step.
  - `cfg_ch` out of range is impossible at NUM_CH=4, so the bench reruns with NUM_CH=3: a write to ch3 gives no ack and no state change.
  - Back-to-back writes to ch0 and ch1 on consecutive cycles both ack.
- Reset mid-BREATHE together with a `cfg_wr` in the same cycle: all channels OFF, no ack, `led`=0 on the next cycle.
